// File: rtl/ms_stage_pkg.sv
// Shared widths, load encodings, bundle layouts and extension helpers for the
// memory-access (MS) pipeline stage.
package ms_stage_pkg;

    localparam int CSR_ZIP_W   = 79;
    localparam int EXC_W       = 7;
    localparam int ES2MS_W     = 1 + 4 + CSR_ZIP_W + EXC_W + 32;
    localparam int MS2WS_W     = 1 + 5 + 32 + CSR_ZIP_W + EXC_W + 32;
    localparam int ES_RF_ZIP_W = 40;
    localparam int MS_RF_ZIP_W = 39;
    localparam int ALE_BIT     = 6;

    localparam logic [3:0] MEM_W = 4'hf;
    localparam logic [3:0] MEM_H = 4'h3;
    localparam logic [3:0] MEM_B = 4'h1;

    typedef struct packed {
        logic                 mem_re_s;
        logic [3:0]           mem_re;
        logic [CSR_ZIP_W-1:0] csr_zip;
        logic [EXC_W-1:0]     except_zip;
        logic [31:0]          pc;
    } es2ms_t;

    typedef struct packed {
        logic        csr_re;
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } es_rf_t;

    function automatic logic [31:0] ext_byte(input logic [7:0] val, input logic sgn);
        return {{24{sgn & val[7]}}, val};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] val, input logic sgn);
        return {{16{sgn & val[15]}}, val};
    endfunction

endpackage

// File: rtl/ms_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword/word out of
// the read data and sign- or zero-extends it to 32 bits.
module ms_stage_load_align
    import ms_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [3:0]  mem_re,
    input  logic        mem_re_s,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte lane selection by address offset
    always_comb begin
        byte_s = 8'h00;
        case (off)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
    end

    // Halfword lane selection by address offset
    always_comb begin
        half_s = 16'h0000;
        if (off[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Width select and extension; unknown encodings load zero
    always_comb begin
        result = 32'h0000_0000;
        case (mem_re)
            MEM_W:   result = rdata;
            MEM_H:   result = ext_half(half_s, mem_re_s);
            MEM_B:   result = ext_byte(byte_s, mem_re_s);
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/ms_stage.sv
// Memory-access pipeline stage: latches the EX bundle, holds SRAM read data
// across WB stalls, aligns loads and hands the result to WB and forwarding.
module ms_stage
    import ms_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ms_allowin,
    input  logic                   es2ms_valid,
    input  logic [ES2MS_W-1:0]     es2ms_bus,
    input  logic [ES_RF_ZIP_W-1:0] es_rf_zip,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   ws_allowin,
    output logic                   ms2ws_valid,
    output logic [MS2WS_W-1:0]     ms2ws_bus,
    output logic [MS_RF_ZIP_W-1:0] ms_rf_zip,
    output logic                   ms_ex,
    input  logic                   ws_ex
);

    logic        ms_valid_r;
    es2ms_t      es_r;
    es_rf_t      rf_r;
    logic [31:0] rbuf_r;
    logic        rbuf_valid_r;

    logic        accept_s;
    logic [31:0] rdata_s;
    logic [31:0] load_result_s;
    logic [31:0] final_wdata_s;
    logic        exc_any_s;
    logic        out_we_s;

    assign ms_allowin = ~ms_valid_r | ws_allowin;
    assign accept_s   = es2ms_valid & ms_allowin;

    // Stage occupancy; a WB flush overrides any incoming instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_r <= 1'b0;
        end else if (ws_ex) begin
            ms_valid_r <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid_r <= es2ms_valid;
        end
    end

    // Bundle latch on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_r <= '0;
            rf_r <= '0;
        end else if (accept_s) begin
            es_r <= es2ms_t'(es2ms_bus);
            rf_r <= es_rf_t'(es_rf_zip);
        end
    end

    // The SRAM only presents data for one cycle, so keep it if WB stalls us
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rbuf_r       <= 32'h0000_0000;
            rbuf_valid_r <= 1'b0;
        end else if (accept_s) begin
            rbuf_valid_r <= 1'b0;
        end else if (ms_valid_r && !rbuf_valid_r && !ws_allowin) begin
            rbuf_r       <= data_sram_rdata;
            rbuf_valid_r <= 1'b1;
        end
    end

    // Effective read data: live SRAM output until buffered
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (rbuf_valid_r) begin
            rdata_s = rbuf_r;
        end else begin
            rdata_s = data_sram_rdata;
        end
    end

    ms_stage_load_align u_load_align (
        .rdata    (rdata_s),
        .off      (rf_r.rf_wdata[1:0]),
        .mem_re   (es_r.mem_re),
        .mem_re_s (es_r.mem_re_s),
        .result   (load_result_s)
    );

    // Write-back value selection
    always_comb begin
        final_wdata_s = 32'h0000_0000;
        if (rf_r.res_from_mem) begin
            final_wdata_s = load_result_s;
        end else begin
            final_wdata_s = rf_r.rf_wdata;
        end
    end

    assign exc_any_s = es_r.except_zip[ALE_BIT] | (|es_r.except_zip[ALE_BIT-1:0]);
    assign ms_ex     = ms_valid_r & exc_any_s;
    // An excepting instruction must never update the register file
    assign out_we_s  = rf_r.rf_we & ms_valid_r & ~ms_ex;

    assign ms2ws_valid = ms_valid_r;
    assign ms2ws_bus   = {out_we_s, rf_r.rf_waddr, final_wdata_s,
                          es_r.csr_zip, es_r.except_zip, es_r.pc};
    assign ms_rf_zip   = {rf_r.csr_re & ms_valid_r, out_we_s, rf_r.rf_waddr, final_wdata_s};

endmodule

// File: tb/tb_ms_stage.sv
// Directed testbench for ms_stage: load extension, WB stall buffering,
// exceptions, flush and asynchronous reset.
module tb_ms_stage;
    import ms_stage_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   ms_allowin;
    logic                   es2ms_valid;
    logic [ES2MS_W-1:0]     es2ms_bus;
    logic [ES_RF_ZIP_W-1:0] es_rf_zip;
    logic [31:0]            data_sram_rdata;
    logic                   ws_allowin;
    logic                   ms2ws_valid;
    logic [MS2WS_W-1:0]     ms2ws_bus;
    logic [MS_RF_ZIP_W-1:0] ms_rf_zip;
    logic                   ms_ex;
    logic                   ws_ex;

    int tests_run    = 0;
    int tests_failed = 0;

    ms_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es2ms_valid     (es2ms_valid),
        .es2ms_bus       (es2ms_bus),
        .es_rf_zip       (es_rf_zip),
        .data_sram_rdata (data_sram_rdata),
        .ws_allowin      (ws_allowin),
        .ms2ws_valid     (ms2ws_valid),
        .ms2ws_bus       (ms2ws_bus),
        .ms_rf_zip       (ms_rf_zip),
        .ms_ex           (ms_ex),
        .ws_ex           (ws_ex)
    );

    always #5 clk = ~clk;

    function automatic logic [ES2MS_W-1:0] mk_es(input logic s, input logic [3:0] re,
                                                  input logic [EXC_W-1:0] exc, input logic [31:0] pc);
        logic [CSR_ZIP_W-1:0] csr;
        csr = {47'h0, pc};
        return {s, re, csr, exc, pc};
    endfunction

    function automatic logic [ES_RF_ZIP_W-1:0] mk_rf(input logic csr_re, input logic rfm, input logic we,
                                                      input logic [4:0] waddr, input logic [31:0] wdata);
        return {csr_re, rfm, we, waddr, wdata};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [ES2MS_W-1:0] bus, input logic [ES_RF_ZIP_W-1:0] rf);
        es2ms_valid = 1'b1;
        es2ms_bus   = bus;
        es_rf_zip   = rf;
        step();
        es2ms_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        es2ms_valid     = 1'b0;
        es2ms_bus       = '0;
        es_rf_zip       = '0;
        data_sram_rdata = 32'h0;
        ws_allowin      = 1'b1;
        ws_ex           = 1'b0;
        #12;
        tests_run++;
        if (ms_allowin !== 1'b1) begin
            tests_failed++; $display("FAIL reset_allowin: got %b expected 1", ms_allowin);
        end
        tests_run++;
        if (ms2ws_valid !== 1'b0 || ms_ex !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid_ex: got %b/%b expected 0/0", ms2ws_valid, ms_ex);
        end
        tests_run++;
        if (ms_rf_zip !== 39'h0 || ms2ws_bus !== '0) begin
            tests_failed++; $display("FAIL reset_bundles: got %h expected 0", ms_rf_zip);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_load_ext();
        ws_allowin = 1'b1;
        // ld.b signed, offset 2
        issue(mk_es(1'b1, 4'h1, 7'h0, 32'h1c00_0000), mk_rf(1'b0, 1'b1, 1'b1, 5'd5, 32'h1000_0002));
        data_sram_rdata = 32'h1280_3456;
        #1;
        tests_run++;
        if (ms_rf_zip !== {1'b0, 1'b1, 5'd5, 32'hFFFF_FF80}) begin
            tests_failed++; $display("FAIL ld_b_signed: got %h expected %h", ms_rf_zip, {1'b0, 1'b1, 5'd5, 32'hFFFF_FF80});
        end
        // ld.hu, offset 2
        issue(mk_es(1'b0, 4'h3, 7'h0, 32'h1c00_0004), mk_rf(1'b0, 1'b1, 1'b1, 5'd6, 32'h1000_0002));
        data_sram_rdata = 32'h8001_7FFF;
        #1;
        tests_run++;
        if (ms_rf_zip[31:0] !== 32'h0000_8001) begin
            tests_failed++; $display("FAIL ld_hu_off2: got %h expected 00008001", ms_rf_zip[31:0]);
        end
        // ld.hu, offset 0
        issue(mk_es(1'b0, 4'h3, 7'h0, 32'h1c00_0008), mk_rf(1'b0, 1'b1, 1'b1, 5'd6, 32'h1000_0000));
        data_sram_rdata = 32'h8001_7FFF;
        #1;
        tests_run++;
        if (ms_rf_zip[31:0] !== 32'h0000_7FFF) begin
            tests_failed++; $display("FAIL ld_hu_off0: got %h expected 00007fff", ms_rf_zip[31:0]);
        end
        // ld.h signed, offset 0
        issue(mk_es(1'b1, 4'h3, 7'h0, 32'h1c00_000c), mk_rf(1'b0, 1'b1, 1'b1, 5'd7, 32'h1000_0000));
        data_sram_rdata = 32'h0000_8001;
        #1;
        tests_run++;
        if (ms_rf_zip[31:0] !== 32'hFFFF_8001) begin
            tests_failed++; $display("FAIL ld_h_signed: got %h expected ffff8001", ms_rf_zip[31:0]);
        end
        // ld.bu, offset 3 (top lane)
        issue(mk_es(1'b0, 4'h1, 7'h0, 32'h1c00_0010), mk_rf(1'b0, 1'b1, 1'b1, 5'd8, 32'h1000_0003));
        data_sram_rdata = 32'hA512_3456;
        #1;
        tests_run++;
        if (ms_rf_zip[31:0] !== 32'h0000_00A5) begin
            tests_failed++; $display("FAIL ld_bu_off3: got %h expected 000000a5", ms_rf_zip[31:0]);
        end
        // ld.w
        issue(mk_es(1'b1, 4'hf, 7'h0, 32'h1c00_0014), mk_rf(1'b0, 1'b1, 1'b1, 5'd9, 32'h1000_0000));
        data_sram_rdata = 32'h8765_4321;
        #1;
        tests_run++;
        if (ms_rf_zip[31:0] !== 32'h8765_4321) begin
            tests_failed++; $display("FAIL ld_w: got %h expected 87654321", ms_rf_zip[31:0]);
        end
        // unsupported mem_re encoding loads zero
        issue(mk_es(1'b1, 4'h2, 7'h0, 32'h1c00_0018), mk_rf(1'b0, 1'b1, 1'b1, 5'd9, 32'h1000_0000));
        data_sram_rdata = 32'hFFFF_FFFF;
        #1;
        tests_run++;
        if (ms_rf_zip[31:0] !== 32'h0000_0000) begin
            tests_failed++; $display("FAIL ld_bad_re: got %h expected 00000000", ms_rf_zip[31:0]);
        end
        // ALU result passes through, csr_re forwarded
        issue(mk_es(1'b0, 4'hf, 7'h0, 32'h1c00_001c), mk_rf(1'b1, 1'b0, 1'b1, 5'd3, 32'hCAFE_F00D));
        data_sram_rdata = 32'h1111_1111;
        #1;
        tests_run++;
        if (ms_rf_zip !== {1'b1, 1'b1, 5'd3, 32'hCAFE_F00D}) begin
            tests_failed++; $display("FAIL alu_pass: got %h expected %h", ms_rf_zip, {1'b1, 1'b1, 5'd3, 32'hCAFE_F00D});
        end
        tests_run++;
        if (ms2ws_bus[31:0] !== 32'h1c00_001c || ms2ws_bus[117:39] !== {47'h0, 32'h1c00_001c}) begin
            tests_failed++; $display("FAIL pc_csr_pass: got %h expected 1c00001c", ms2ws_bus[31:0]);
        end
        step();
    endtask

    task automatic test_wb_stall();
        logic [31:0] wd;
        ws_allowin = 1'b1;
        issue(mk_es(1'b0, 4'hf, 7'h0, 32'h1c00_0100), mk_rf(1'b0, 1'b1, 1'b1, 5'd9, 32'h2000_0000));
        data_sram_rdata = 32'hDEAD_BEEF;
        ws_allowin      = 1'b0;
        #1;
        tests_run++;
        if (ms_allowin !== 1'b0) begin
            tests_failed++; $display("FAIL stall_allowin0: got %b expected 0", ms_allowin);
        end
        step();
        data_sram_rdata = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            wd = ms2ws_bus[149:118];
            tests_run++;
            if (ms_allowin !== 1'b0 || ms2ws_valid !== 1'b1 || wd !== 32'hDEAD_BEEF) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got allowin=%b valid=%b wdata=%h expected 0 1 deadbeef",
                         i, ms_allowin, ms2ws_valid, wd);
            end
            step();
        end
        ws_allowin  = 1'b1;
        es2ms_valid = 1'b1;
        es2ms_bus   = mk_es(1'b0, 4'hf, 7'h0, 32'h1c00_0104);
        es_rf_zip   = mk_rf(1'b0, 1'b1, 1'b1, 5'd10, 32'h2000_0004);
        #1;
        wd = ms2ws_bus[149:118];
        tests_run++;
        if (wd !== 32'hDEAD_BEEF || ms_allowin !== 1'b1) begin
            tests_failed++; $display("FAIL stall_release: got wdata=%h allowin=%b expected deadbeef 1", wd, ms_allowin);
        end
        step();
        es2ms_valid     = 1'b0;
        data_sram_rdata = 32'h1122_3344;
        #1;
        tests_run++;
        if (ms_rf_zip !== {1'b0, 1'b1, 5'd10, 32'h1122_3344}) begin
            tests_failed++; $display("FAIL after_stall_fresh: got %h expected %h", ms_rf_zip, {1'b0, 1'b1, 5'd10, 32'h1122_3344});
        end
        step();
        tests_run++;
        if (ms2ws_valid !== 1'b0) begin
            tests_failed++; $display("FAIL drain: got %b expected 0", ms2ws_valid);
        end
    endtask

    task automatic test_exception();
        ws_allowin = 1'b1;
        issue(mk_es(1'b0, 4'h0, 7'h40, 32'h1c00_0200), mk_rf(1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0055));
        #1;
        tests_run++;
        if (ms_ex !== 1'b1 || ms2ws_valid !== 1'b1) begin
            tests_failed++; $display("FAIL ale_ex: got ex=%b valid=%b expected 1 1", ms_ex, ms2ws_valid);
        end
        tests_run++;
        if (ms2ws_bus[155] !== 1'b0 || ms_rf_zip[37] !== 1'b0) begin
            tests_failed++; $display("FAIL ale_no_we: got %b/%b expected 0/0", ms2ws_bus[155], ms_rf_zip[37]);
        end
        tests_run++;
        if (ms2ws_bus[38:32] !== 7'h40) begin
            tests_failed++; $display("FAIL ale_exc_pass: got %h expected 40", ms2ws_bus[38:32]);
        end
        issue(mk_es(1'b0, 4'h0, 7'h01, 32'h1c00_0204), mk_rf(1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0055));
        #1;
        tests_run++;
        if (ms_ex !== 1'b1 || ms2ws_bus[155] !== 1'b0) begin
            tests_failed++; $display("FAIL early_ex: got ex=%b we=%b expected 1 0", ms_ex, ms2ws_bus[155]);
        end
        issue(mk_es(1'b0, 4'h0, 7'h00, 32'h1c00_0208), mk_rf(1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0055));
        #1;
        tests_run++;
        if (ms_ex !== 1'b0 || ms2ws_bus[155] !== 1'b1) begin
            tests_failed++; $display("FAIL no_ex: got ex=%b we=%b expected 0 1", ms_ex, ms2ws_bus[155]);
        end
        step();
    endtask

    task automatic test_flush();
        ws_allowin = 1'b1;
        issue(mk_es(1'b0, 4'h0, 7'h0, 32'h1c00_0300), mk_rf(1'b0, 1'b0, 1'b1, 5'd4, 32'h1));
        es2ms_valid = 1'b1;
        es2ms_bus   = mk_es(1'b0, 4'h0, 7'h0, 32'h1c00_0304);
        es_rf_zip   = mk_rf(1'b0, 1'b0, 1'b1, 5'd4, 32'h2);
        ws_ex       = 1'b1;
        step();
        es2ms_valid = 1'b0;
        ws_ex       = 1'b0;
        tests_run++;
        if (ms2ws_valid !== 1'b0 || ms_ex !== 1'b0 || ms_rf_zip[37] !== 1'b0) begin
            tests_failed++; $display("FAIL flush_accept: got valid=%b ex=%b we=%b expected 0 0 0", ms2ws_valid, ms_ex, ms_rf_zip[37]);
        end
        issue(mk_es(1'b0, 4'h0, 7'h0, 32'h1c00_0308), mk_rf(1'b0, 1'b0, 1'b1, 5'd4, 32'h3));
        ws_allowin = 1'b0;
        ws_ex      = 1'b1;
        step();
        ws_ex      = 1'b0;
        ws_allowin = 1'b1;
        #1;
        tests_run++;
        if (ms2ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
            tests_failed++; $display("FAIL flush_stalled: got valid=%b allowin=%b expected 0 1", ms2ws_valid, ms_allowin);
        end
    endtask

    task automatic test_reset_mid();
        ws_allowin = 1'b1;
        issue(mk_es(1'b0, 4'h0, 7'h0, 32'h1c00_0400), mk_rf(1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_ABCD));
        #1;
        tests_run++;
        if (ms2ws_valid !== 1'b1) begin
            tests_failed++; $display("FAIL pre_reset_valid: got %b expected 1", ms2ws_valid);
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (ms2ws_valid !== 1'b0 || ms_rf_zip !== 39'h0 || ms_allowin !== 1'b1) begin
            tests_failed++; $display("FAIL async_reset: got valid=%b zip=%h allowin=%b expected 0 0 1", ms2ws_valid, ms_rf_zip, ms_allowin);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_wb_stall();
        test_exception();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ms_stage.md
Name: ms_stage

Overview:
- Memory-access (MS) pipeline stage; the receiving end of the EX→MS valid/allowin handshake and of the data-SRAM read path.
- Accepts the EX bundle (es2ms_bus plus es_rf_zip) and captures the synchronous SRAM read data returned one cycle after the EX-stage request.
- Performs load byte/halfword extraction with sign/zero extension and selects the register write-back value.
- Drives the MS→WB handshake and bundle, the MS forwarding bundle, and the MS exception flag.

Parameters:
- CSR_ZIP_W, 79, width of opaque CSR bundle passed through.
- EXC_W, 7, width of exception bundle (bit 6 = ALE from EX, [5:0] earlier causes).
- ES2MS_W, 123, must equal 1+4+CSR_ZIP_W+EXC_W+32.
- MS2WS_W, 156, must equal 1+5+32+CSR_ZIP_W+EXC_W+32.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ms_allowin  out  1  MS can accept a new instruction.
- es2ms_valid  in  1  EX has a valid instruction for MS.
- es2ms_bus  in  ES2MS_W  {mem_re_s, mem_re[3:0], csr_zip, except_zip, pc}, MSB first.
- es_rf_zip  in  40  {csr_re, res_from_mem, rf_we, rf_waddr[4:0], rf_wdata[31:0]}; rf_wdata[1:0] is the load address offset.
- data_sram_rdata  in  32  SRAM read data, valid in the cycle after EX issued en.
- ws_allowin  in  1  WB can accept.
- ms2ws_valid  out  1  MS instruction is ready for WB.
- ms2ws_bus  out  MS2WS_W  {rf_we, rf_waddr, rf_wdata, csr_zip, except_zip, pc}.
- ms_rf_zip  out  39  {csr_re&valid, rf_we&valid, rf_waddr, final_wdata}, used by decode forwarding/stall.
- ms_ex  out  1  valid MS instruction carries any exception.
- ws_ex  in  1  WB exception/ertn flush.

Behaviour:
- Reset (async, active-high): ms_valid=0, all latched bundle fields=0, rdata buffer=0, rbuf_valid=0. Consequently ms2ws_valid=0, ms_ex=0, ms_rf_zip=0, and ms_allowin=1.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = ~ms_valid | ws_allowin.
  - ms2ws_valid = ms_valid.
  - ms_valid: on ws_ex → 0 (takes priority); else if ms_allowin → es2ms_valid.
- Bundle latch: when es2ms_valid & ms_allowin, latch es2ms_bus and es_rf_zip in the same edge; otherwise hold.
- Read-data capture:
  - rbuf_valid clears on every accept edge.
  - In the first cycle an instruction is in MS (rbuf_valid=0, ms_valid=1), the effective rdata is data_sram_rdata directly. On that edge, if not advancing (~ws_allowin), store data_sram_rdata in the buffer and set rbuf_valid=1.
  - While rbuf_valid=1, the effective rdata is the buffer. This makes stalls of any length safe.
- Load extraction (off = rf_wdata[1:0]):
  - mem_re=4'hf: word.
  - mem_re=4'h3: half = off[1] ? rdata[31:16] : rdata[15:0].
  - mem_re=4'h1: byte = rdata[8*off +: 8].
  - Extend: sign-extend if mem_re_s=1, else zero-extend.
  - Any other mem_re value: load result = 0.
- final_wdata = res_from_mem ? load_result : rf_wdata.
- ms_ex = ms_valid & |except_zip.
- Output rf_we (both ms2ws_bus and ms_rf_zip) = rf_we & ms_valid & ~ms_ex. No GPR write on an excepting instruction.
- ws_ex in the same cycle as an accept: flush wins, ms_valid=0; latched data is don't-care.
- csr_zip and except_zip pass through unchanged; the ALE bit is already computed in EX.

Decomposition:
- Shared package: bundle widths (ES2MS_W, MS2WS_W, CSR_ZIP_W, EXC_W), mem_re encodings (MEM_W=4'hf, MEM_H=4'h3, MEM_B=4'h1), and the field index of the ALE exception bit.
- One sub-module is natural: load_align (combinational: rdata, off, mem_re, mem_re_s → 32-bit result).

Test Plan:
- ld.b signed: mem_re=1, mem_re_s=1, off=2, rdata=0x12_80_34_56, ws_allowin=1 → ms_rf_zip wdata=0xFFFFFF80, rf_we=1.
- ld.hu: mem_re=3, mem_re_s=0, off=2, rdata=0x8001_7FFF → wdata=0x00008001; off=0 → 0x00007FFF.
- WB stall: load accepted with rdata=0xDEADBEEF; ws_allowin=0 for 3 cycles while data_sram_rdata changes to 0x0 → ms2ws_bus rdata still 0xDEADBEEF on release; ms_allowin=0 during the stall.
- Exception: except_zip=7'h40, rf_we=1 → ms_ex=1, rf_we out=0, ms2ws_valid=1.
- Flush: ws_ex=1 coinciding with es2ms_valid=1 → next cycle ms_valid=0, ms2ws_valid=0.
- Reset mid-stream: assert reset while ms_valid=1 → ms2ws_valid=0, ms_rf_zip=0 immediately (async).
